div_wb_ctrl: RTL and testbench
==============================

Name: div_wb_ctrl

Overview:
Issue and writeback controller for the iterative DIV/REM unit. It takes DIV/DIVU/REM/REMU instructions from decode and starts the divider. It tracks the pending destination register as a single-entry scoreboard and stalls dependent instructions. It captures the divider result and merges it into the shared register-file write port whenever the main pipeline leaves that port free.

Parameters:
XLEN, 32, operand/result width
CNT_W, 16, width of saturating divide-latency performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
id_div_valid  in  1  decode presents a DIV/REM instruction
id_div_opc  in  2  {0:DIV,1:DIVU,2:REM,3:REMU}
id_src1  in  XLEN  dividend
id_src2  in  XLEN  divisor
id_rs1  in  5  source register 1 number
id_rs2  in  5  source register 2 number
id_rd  in  5  destination of the DIV/REM
id_rs1_used  in  1  current decode instruction reads rs1 (any instruction)
id_rs2_used  in  1  current decode instruction reads rs2
id_rd_wr  in  1  current decode instruction writes id_rd
id_stall  out  1  decode must hold its current instruction
dec_start_div  out  1  to divider: start operation
dec_div_opc  out  2  to divider: id_div_opc passthrough
dec_src1  out  XLEN  to divider: id_src1 passthrough
dec_src2  out  XLEN  to divider: id_src2 passthrough
dec_rs1  out  5  to divider: id_rs1 passthrough
dec_rs2  out  5  to divider: id_rs2 passthrough
div_busy  in  1  from divider
div_ready  in  1  from divider: result valid
div_result  in  XLEN  from divider
wrb_restart  in  1  pipeline flush; also routed separately to the divider
pipe_wr_en  in  1  main pipeline uses the register-file write port this cycle (has priority)
div_wr_en  out  1  divider result write enable
div_wr_addr  out  5  divider result destination register
div_wr_data  out  XLEN  divider result data
div_cycles  out  CNT_W  issue-to-writeback cycles of last completed op, saturating

Behaviour:
- Reset puts state in IDLE and clears pend_rd, hold_data, and the counters.
- Reset output values: id_stall=0, dec_start_div=0, div_wr_en=0, div_wr_addr=0, div_wr_data=0, div_cycles=0.
- States:
  - IDLE: no operation outstanding.
  - BUSY: divide in flight.
  - HOLD: result captured, waiting for the write port.
- Hazard signal hz = (state!=IDLE) && pend_rd!=0 && any of:
  - id_rs1_used && id_rs1==pend_rd
  - id_rs2_used && id_rs2==pend_rd
  - id_rd_wr && id_rd==pend_rd (WAW)
- id_stall = !wrb_restart && (hz || (id_div_valid && (state!=IDLE || div_busy))).
- Issue:
  - Condition: state==IDLE && id_div_valid && !div_busy && !wrb_restart.
  - Effect: dec_start_div=1 in that same cycle (combinational). pend_rd<=id_rd, run counter<=1, state<=BUSY.
- div_ready is ignored in the issue cycle and in IDLE. On a result-reuse hit the divider's div_ready is already 1 during the issue cycle; the divider keeps it asserted in DONE, so it is picked up in BUSY the next cycle.
- BUSY:
  - Run counter increments each cycle, saturating at all-ones.
  - On div_ready && !pipe_wr_en: div_wr_en=1, div_wr_addr=pend_rd, div_wr_data=div_result (same cycle). div_cycles<=counter, state<=IDLE.
  - On div_ready && pipe_wr_en: hold_data<=div_result, state<=HOLD.
- HOLD:
  - Run counter keeps incrementing, saturating.
  - When !pipe_wr_en: div_wr_en=1, addr=pend_rd, data=hold_data. div_cycles<=counter, state<=IDLE.
- rd==0: the result still completes the handshake, but div_wr_en stays 0. Scoreboard never matches x0.
- A new DIV cannot issue in the cycle the previous write completes (state still BUSY/HOLD). Earliest reissue is the following cycle.
- wrb_restart takes priority in every state:
  - state<=IDLE, pend_rd<=0.
  - No write, no start that cycle, even if div_ready=1 simultaneously. The result is dropped.
  - div_cycles is unchanged.
- div_wr_en is asserted only when pipe_wr_en=0; the two never collide.
- Outputs are undriven-free: div_wr_addr/div_wr_data are 0 whenever div_wr_en=0.

Test Plan:
- Back-to-back DIVU x5=100/7 then independent ALU op -> start pulse 1 cycle, div_wr_en with addr 5, data 14; no stall on ALU op reading x6.
- REM x7=-7%2, next instr reads x7 -> id_stall high from issue+1 until writeback cycle; data 0xFFFFFFFF; stall drops the cycle after.
- div_ready coincides with pipe_wr_en=1 for 3 cycles -> state HOLD; div_wr_en asserted on 4th cycle with held data; div_cycles = BUSY+HOLD count.
- Reissue of identical DIV after completion (divider reuse, div_ready already 1 at issue) -> no write in issue cycle; write next cycle with correct result, div_cycles=1.
- wrb_restart mid-BUSY and again in the same cycle as div_ready -> no div_wr_en, scoreboard cleared, stall released immediately, div_cycles unchanged.
- DIV with rd=x0 -> no div_wr_en; a following instruction reading x0 is not stalled; controller returns to IDLE.

Source files
------------

// File: rtl/div_wb_ctrl.sv
// Issue/writeback controller for the iterative DIV/REM unit. It tracks one pending destination
// register and merges divider results into the shared register-file write port.
module div_wb_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_div_valid,
  input  logic [1:0]       id_div_opc,
  input  logic [XLEN-1:0]  id_src1,
  input  logic [XLEN-1:0]  id_src2,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_rd_wr,
  output logic             id_stall,
  output logic             dec_start_div,
  output logic [1:0]       dec_div_opc,
  output logic [XLEN-1:0]  dec_src1,
  output logic [XLEN-1:0]  dec_src2,
  output logic [4:0]       dec_rs1,
  output logic [4:0]       dec_rs2,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [XLEN-1:0]  div_result,
  input  logic             wrb_restart,
  input  logic             pipe_wr_en,
  output logic             div_wr_en,
  output logic [4:0]       div_wr_addr,
  output logic [XLEN-1:0]  div_wr_data,
  output logic [CNT_W-1:0] div_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       pend_rd_reg, pend_rd_next;
  logic [XLEN-1:0]  hold_data_reg, hold_data_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0] div_cycles_reg, div_cycles_next;
  logic [CNT_W-1:0] run_cnt_inc;
  logic             done;
  logic [XLEN-1:0]  done_data;
  logic             hz;

  assign dec_div_opc = id_div_opc;
  assign dec_src1    = id_src1;
  assign dec_src2    = id_src2;
  assign dec_rs1     = id_rs1;
  assign dec_rs2     = id_rs2;
  assign div_cycles  = div_cycles_reg;

  assign run_cnt_inc = (&run_cnt_reg) ? run_cnt_reg : run_cnt_reg + 1'b1;

  // x0 is never a real dependency, so a zero pend_rd never matches.
  always_comb begin
    hz = 1'b0;
    if (state_reg != IDLE && pend_rd_reg != 5'd0) begin
      hz = (id_rs1_used && id_rs1 == pend_rd_reg) ||
           (id_rs2_used && id_rs2 == pend_rd_reg) ||
           (id_rd_wr    && id_rd  == pend_rd_reg);
    end
  end

  assign id_stall = !wrb_restart &&
                    (hz || (id_div_valid && (state_reg != IDLE || div_busy)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pend_rd_reg    <= '0;
      hold_data_reg  <= '0;
      run_cnt_reg    <= '0;
      div_cycles_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pend_rd_reg    <= pend_rd_next;
      hold_data_reg  <= hold_data_next;
      run_cnt_reg    <= run_cnt_next;
      div_cycles_reg <= div_cycles_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pend_rd_next    = pend_rd_reg;
    hold_data_next  = hold_data_reg;
    run_cnt_next    = run_cnt_reg;
    div_cycles_next = div_cycles_reg;
    dec_start_div   = 1'b0;
    done            = 1'b0;
    done_data       = '0;

    if (wrb_restart) begin
      // Flush drops whatever is in flight, including a result arriving this cycle.
      state_next   = IDLE;
      pend_rd_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // div_ready here may be a stale reuse hit; it is consumed from BUSY next cycle.
          if (id_div_valid && !div_busy) begin
            dec_start_div = 1'b1;
            pend_rd_next  = id_rd;
            run_cnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
            state_next    = BUSY;
          end
        end
        BUSY: begin
          run_cnt_next = run_cnt_inc;
          if (div_ready) begin
            if (!pipe_wr_en) begin
              done            = 1'b1;
              done_data       = div_result;
              div_cycles_next = run_cnt_reg;
              state_next      = IDLE;
            end else begin
              hold_data_next = div_result;
              state_next     = HOLD;
            end
          end
        end
        HOLD: begin
          run_cnt_next = run_cnt_inc;
          if (!pipe_wr_en) begin
            done            = 1'b1;
            done_data       = hold_data_reg;
            div_cycles_next = run_cnt_reg;
            state_next      = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // A completion to x0 finishes the handshake without touching the register file.
  assign div_wr_en   = done && (pend_rd_reg != 5'd0);
  assign div_wr_addr = div_wr_en ? pend_rd_reg : 5'd0;
  assign div_wr_data = div_wr_en ? done_data : '0;

endmodule

// File: tb/tb_div_wb_ctrl.sv
// Directed bench for div_wb_ctrl: expected writebacks go into a queue that a negedge
// monitor drains whenever the controller drives the write port.
module tb_div_wb_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_div_valid;
  logic [1:0]       id_div_opc;
  logic [XLEN-1:0]  id_src1, id_src2;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used, id_rd_wr;
  logic             id_stall, dec_start_div;
  logic [1:0]       dec_div_opc;
  logic [XLEN-1:0]  dec_src1, dec_src2;
  logic [4:0]       dec_rs1, dec_rs2;
  logic             div_busy, div_ready;
  logic [XLEN-1:0]  div_result;
  logic             wrb_restart, pipe_wr_en;
  logic             div_wr_en;
  logic [4:0]       div_wr_addr;
  logic [XLEN-1:0]  div_wr_data;
  logic [CNT_W-1:0] div_cycles;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  div_wb_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_div_valid(id_div_valid), .id_div_opc(id_div_opc),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_wr(id_rd_wr),
    .id_stall(id_stall), .dec_start_div(dec_start_div), .dec_div_opc(dec_div_opc),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .div_busy(div_busy), .div_ready(div_ready), .div_result(div_result),
    .wrb_restart(wrb_restart), .pipe_wr_en(pipe_wr_en),
    .div_wr_en(div_wr_en), .div_wr_addr(div_wr_addr), .div_wr_data(div_wr_data),
    .div_cycles(div_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_div_valid = 0; id_div_opc = 0; id_src1 = 0; id_src2 = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd_wr = 0;
    div_busy = 0; div_ready = 0; div_result = 0;
    wrb_restart = 0; pipe_wr_en = 0;
  endtask

  task automatic set_div(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    id_div_valid = 1; id_div_opc = opc; id_src1 = a; id_src2 = b;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = rd;
    id_rs1_used = 1; id_rs2_used = 1; id_rd_wr = 1;
  endtask

  task automatic set_alu(input logic [4:0] rs1, input logic [4:0] rd);
    id_div_valid = 0; id_rs1 = rs1; id_rs2 = 5'd0; id_rd = rd;
    id_rs1_used = 1; id_rs2_used = 0; id_rd_wr = 1;
  endtask

  // Every register-file write from the controller must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && div_wr_en) begin
      wr_t e;
      n_vec++;
      if (pipe_wr_en) begin
        n_err++;
        $display("FAIL wr_collision: div_wr_en=1 while pipe_wr_en=1");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: addr %0d data %h, expected no write", div_wr_addr, div_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (div_wr_addr !== e.addr || div_wr_data !== e.data) begin
          n_err++;
          $display("FAIL wr_result: got x%0d=%h, expected x%0d=%h",
                   div_wr_addr, div_wr_data, e.addr, e.data);
        end else begin
          $display("write x%0d=%h ok", div_wr_addr, div_wr_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk("rst_stall", {31'd0, id_stall}, 0);
    chk("rst_start", {31'd0, dec_start_div}, 0);
    chk("rst_wr_en", {31'd0, div_wr_en}, 0);
    chk("rst_wr_addr", {27'd0, div_wr_addr}, 0);
    chk("rst_wr_data", div_wr_data, 0);
    chk("rst_cycles", {16'd0, div_cycles}, 0);
    next_cycle();
    reset = 0;

    // DIVU x5 = 100/7, then an unrelated ALU op reading x6
    set_div(2'd1, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    chk("t1_start", {31'd0, dec_start_div}, 1);
    chk("t1_stall_issue", {31'd0, id_stall}, 0);
    chk("t1_src1", dec_src1, 100);
    chk("t1_opc", {30'd0, dec_div_opc}, 1);
    exp_q.push_back('{addr: 5'd5, data: 32'd14});
    next_cycle();
    set_alu(5'd6, 5'd8); div_busy = 1;
    @(negedge clk);
    chk("t1_start_pulse", {31'd0, dec_start_div}, 0);
    chk("t1_alu_stall", {31'd0, id_stall}, 0);
    next_cycle();
    div_busy = 0; div_ready = 1; div_result = 32'd14;
    @(negedge clk);
    chk("t1_wb_en", {31'd0, div_wr_en}, 1);
    chk("t1_alu_stall_wb", {31'd0, id_stall}, 0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("t1_cycles", {16'd0, div_cycles}, 2);
    chk("t1_idle_wr", {31'd0, div_wr_en}, 0);
    next_cycle();

    // REM x7 = -7 % 2 with a dependent reader of x7
    set_div(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd7);
    @(negedge clk);
    chk("t2_start", {31'd0, dec_start_div}, 1);
    exp_q.push_back('{addr: 5'd7, data: 32'hFFFF_FFFF});
    next_cycle();
    set_alu(5'd7, 5'd9); div_busy = 1;
    @(negedge clk);
    chk("t2_stall_c1", {31'd0, id_stall}, 1);
    next_cycle();
    @(negedge clk);
    chk("t2_stall_c2", {31'd0, id_stall}, 1);
    next_cycle();
    div_busy = 0; div_ready = 1; div_result = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t2_stall_wb", {31'd0, id_stall}, 1);
    next_cycle();
    div_ready = 0; div_result = 0;
    @(negedge clk);
    chk("t2_stall_after", {31'd0, id_stall}, 0);
    chk("t2_cycles", {16'd0, div_cycles}, 3);
    next_cycle();
    clear_inputs();

    // DIV x9 = 100 / -3 with the write port busy for 3 cycles
    set_div(2'd0, 32'd100, 32'hFFFF_FFFD, 5'd9);
    @(negedge clk);
    chk("t3_start", {31'd0, dec_start_div}, 1);
    exp_q.push_back('{addr: 5'd9, data: 32'hFFFF_FFDF});
    next_cycle();
    clear_inputs(); div_busy = 1;
    next_cycle();
    div_busy = 0; div_ready = 1; div_result = 32'hFFFF_FFDF; pipe_wr_en = 1;
    @(negedge clk);
    chk("t3_hold_c1", {31'd0, div_wr_en}, 0);
    next_cycle();
    div_ready = 0; div_result = 32'h0000_DEAD;
    @(negedge clk);
    chk("t3_hold_c2", {31'd0, div_wr_en}, 0);
    next_cycle();
    @(negedge clk);
    chk("t3_hold_c3", {31'd0, div_wr_en}, 0);
    next_cycle();
    pipe_wr_en = 0;
    set_div(2'd0, 32'd100, 32'hFFFF_FFFD, 5'd9);
    @(negedge clk);
    chk("t3_wb_en", {31'd0, div_wr_en}, 1);
    chk("t3_no_reissue", {31'd0, dec_start_div}, 0);
    chk("t3_reissue_stall", {31'd0, id_stall}, 1);
    next_cycle();

    // Reissue with a reuse hit: div_ready already high at issue
    div_ready = 1; div_result = 32'hFFFF_FFDF;
    @(negedge clk);
    chk("t3_cycles", {16'd0, div_cycles}, 5);
    chk("t4_start", {31'd0, dec_start_div}, 1);
    chk("t4_no_wr_issue", {31'd0, div_wr_en}, 0);
    exp_q.push_back('{addr: 5'd9, data: 32'hFFFF_FFDF});
    next_cycle();
    id_div_valid = 0; id_rd_wr = 0; id_rs1_used = 0; id_rs2_used = 0;
    @(negedge clk);
    chk("t4_wb_en", {31'd0, div_wr_en}, 1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("t4_cycles", {16'd0, div_cycles}, 1);
    next_cycle();

    // Flush in IDLE blocks the start
    set_div(2'd0, 32'd50, 32'd5, 5'd10); wrb_restart = 1;
    @(negedge clk);
    chk("t5_idle_flush_start", {31'd0, dec_start_div}, 0);
    chk("t5_idle_flush_stall", {31'd0, id_stall}, 0);
    next_cycle();
    wrb_restart = 0;
    @(negedge clk);
    chk("t5_start", {31'd0, dec_start_div}, 1);
    next_cycle();
    set_alu(5'd10, 5'd11); div_busy = 1;
    @(negedge clk);
    chk("t5_stall_busy", {31'd0, id_stall}, 1);
    next_cycle();
    wrb_restart = 1;
    @(negedge clk);
    chk("t5_flush_stall", {31'd0, id_stall}, 0);
    chk("t5_flush_wr", {31'd0, div_wr_en}, 0);
    next_cycle();
    wrb_restart = 0; div_busy = 0;
    @(negedge clk);
    chk("t5_sb_cleared", {31'd0, id_stall}, 0);
    chk("t5_cycles_kept", {16'd0, div_cycles}, 1);
    next_cycle();

    // Flush coincident with div_ready drops the result
    set_div(2'd1, 32'd9, 32'd3, 5'd11);
    @(negedge clk);
    chk("t5b_start", {31'd0, dec_start_div}, 1);
    next_cycle();
    wrb_restart = 1; div_ready = 1; div_result = 32'd3;
    @(negedge clk);
    chk("t5b_flush_wr", {31'd0, div_wr_en}, 0);
    chk("t5b_flush_start", {31'd0, dec_start_div}, 0);
    next_cycle();
    clear_inputs(); set_alu(5'd11, 5'd12);
    @(negedge clk);
    chk("t5b_no_wr", {31'd0, div_wr_en}, 0);
    chk("t5b_stall", {31'd0, id_stall}, 0);
    chk("t5b_cycles_kept", {16'd0, div_cycles}, 1);
    next_cycle();
    clear_inputs();

    // DIVU x0 = 8/2: completes silently, x0 readers are never stalled
    set_div(2'd1, 32'd8, 32'd2, 5'd0);
    @(negedge clk);
    chk("t6_start", {31'd0, dec_start_div}, 1);
    next_cycle();
    set_alu(5'd0, 5'd13); div_busy = 1;
    @(negedge clk);
    chk("t6_x0_stall", {31'd0, id_stall}, 0);
    next_cycle();
    div_busy = 0; div_ready = 1; div_result = 32'd4;
    @(negedge clk);
    chk("t6_x0_no_wr", {31'd0, div_wr_en}, 0);
    next_cycle();
    clear_inputs();
    set_div(2'd1, 32'd20, 32'd4, 5'd12);
    @(negedge clk);
    chk("t6_idle_again", {31'd0, dec_start_div}, 1);
    chk("t6_cycles", {16'd0, div_cycles}, 2);
    exp_q.push_back('{addr: 5'd12, data: 32'd5});
    next_cycle();
    clear_inputs(); div_ready = 1; div_result = 32'd5;
    next_cycle();
    clear_inputs();
    next_cycle(); next_cycle();

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
